// File: rtl/display_pkg.sv
// Shared types and constants for the hex scan display controller.
// No logic of its own: state encoding, segment table and select helper.
// Imported by the scan top and the segment lookup.
package display_pkg;

    // Scan sequencer states
    typedef enum logic [1:0] {
        OFF   = 2'd0,
        DRIVE = 2'd1,
        GUARD = 2'd2
    } state_t;

    // Segment patterns {a,b,c,d,e,f,g}, active-high; entry 15 first in the concatenation
    localparam logic [15:0][6:0] SEG_HEX = {
        7'h47, 7'h4F, 7'h3D, 7'h4E,   // F E d C
        7'h1F, 7'h77, 7'h7B, 7'h7F,   // b A 9 8
        7'h70, 7'h5F, 7'h5B, 7'h33,   // 7 6 5 4
        7'h79, 7'h6D, 7'h30, 7'h7E    // 3 2 1 0
    };

    localparam logic [6:0] SEG_OFF = 7'h00;

    // Active-low digit select with only bit [idx] low; callers truncate to their digit count
    function automatic logic [7:0] dig_onecold(input logic [2:0] idx);
        return ~(8'b1 << idx);
    endfunction

endpackage

// File: rtl/display_mux_hex_scan_if.sv
// Bundle between the datapath, the scan controller and the display pins.
// Pure wiring, no latency.
// No backpressure: load is a fire-and-forget strobe, outputs run freely.
interface display_mux_hex_scan_if #(
    parameter int N_DIGITS = 4
) ();
    logic                    enable;
    logic                    load;
    logic [4*N_DIGITS-1:0]   data_in;
    logic [6:0]              seg;
    logic [N_DIGITS-1:0]     dig_n;
    logic                    frame_done;

    // Datapath side: drives value and control, observes display pins
    modport master (
        output enable, load, data_in,
        input  seg, dig_n, frame_done
    );

    // Scan controller side
    modport slave (
        input  enable, load, data_in,
        output seg, dig_n, frame_done
    );
endinterface

// File: rtl/hex_7seg_lut.sv
// Hex nibble to 7-segment pattern lookup.
// Purely combinational, zero latency.
// No flow control.
module hex_7seg_lut
    import display_pkg::*;
(
    input  logic [3:0] nib,
    output logic [6:0] seg
);

    assign seg = SEG_HEX[nib];

endmodule

// File: rtl/display_mux_hex_scan.sv
// Time-multiplexed N-digit 7-segment scanner with a double-buffered value and guard gaps.
// Outputs registered one cycle behind the sequencer; a loaded value shows from the next frame start.
// No backpressure: a load always lands in the shadow buffer (last wins). Option: LEADING_ZERO_BLANK_EN.
module display_mux_hex_scan
    import display_pkg::*;
#(
    parameter int N_DIGITS  = 4,
    parameter int DWELL_CYC = 50000,
    parameter int GUARD_CYC = 500
) (
    input  logic clk,
    input  logic rst_n,
    display_mux_hex_scan_if.slave bus
);

    localparam int MAX_CYC = (DWELL_CYC > GUARD_CYC) ? DWELL_CYC : GUARD_CYC;
    localparam int PW      = $clog2(MAX_CYC);
    localparam int IW      = $clog2(N_DIGITS);

    localparam logic [PW-1:0] DWELL_LAST = PW'(DWELL_CYC - 1);
    localparam logic [PW-1:0] GUARD_LAST = PW'(GUARD_CYC - 1);
    localparam logic [IW-1:0] IDX_LAST   = IW'(N_DIGITS - 1);

    state_t                   state, state_nx;
    logic [IW-1:0]            idx, idx_nx;
    logic [PW-1:0]            presc, presc_nx;
    logic                     boundary;

    logic [N_DIGITS-1:0][3:0] shadow;
    logic [N_DIGITS-1:0][3:0] active;
    logic                     pending;

    logic [3:0]               cur_nib;
    logic [6:0]               lut_seg;
    logic                     blank;

    logic [6:0]               seg_q;
    logic [N_DIGITS-1:0]      dig_n_q;
    logic                     frame_done_q;

    // Sequencer state register
    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            state <= OFF;
            idx   <= '0;
            presc <= '0;
        end else begin
            state <= state_nx;
            idx   <= idx_nx;
            presc <= presc_nx;
        end
    end

    // Next-state: dwell/guard timing per digit, frame boundary after the last guard
    always_comb begin
        state_nx = state;
        idx_nx   = idx;
        presc_nx = presc;
        boundary = 1'b0;
        if (!bus.enable) begin
            // Abandon any partial frame; buffers are left alone
            state_nx = OFF;
            idx_nx   = '0;
            presc_nx = '0;
        end else begin
            case (state)
                OFF: begin
                    state_nx = DRIVE;
                    idx_nx   = '0;
                    presc_nx = '0;
                end
                DRIVE: begin
                    if (presc == DWELL_LAST) begin
                        state_nx = GUARD;
                        presc_nx = '0;
                    end else begin
                        presc_nx = presc + PW'(1);
                    end
                end
                GUARD: begin
                    if (presc == GUARD_LAST) begin
                        state_nx = DRIVE;
                        presc_nx = '0;
                        if (idx == IDX_LAST) begin
                            idx_nx   = '0;
                            boundary = 1'b1;
                        end else begin
                            idx_nx = idx + IW'(1);
                        end
                    end else begin
                        presc_nx = presc + PW'(1);
                    end
                end
                default: begin
                    state_nx = OFF;
                    idx_nx   = '0;
                    presc_nx = '0;
                end
            endcase
        end
    end

    // Double buffer: loads park in shadow, frame boundary publishes; a boundary-coincident load bypasses
    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            shadow  <= '0;
            active  <= '0;
            pending <= 1'b0;
        end else if (boundary) begin
            if (bus.load) begin
                active <= bus.data_in;
                shadow <= bus.data_in;
            end else if (pending) begin
                active <= shadow;
            end
            pending <= 1'b0;
        end else if (bus.load) begin
            shadow  <= bus.data_in;
            pending <= 1'b1;
        end
    end

    assign cur_nib = active[idx];

    hex_7seg_lut u_lut (
        .nib (cur_nib),
        .seg (lut_seg)
    );

`ifdef LEADING_ZERO_BLANK_EN
    logic [N_DIGITS-1:0] blank_lz;

    // Digit k>0 is blanked when it and every more significant nibble are zero
    always_comb begin
        logic zero_run;
        blank_lz = '0;
        zero_run = 1'b1;
        for (int k = N_DIGITS - 1; k > 0; k--) begin
            zero_run    = zero_run && (active[k] == 4'h0);
            blank_lz[k] = zero_run;
        end
    end

    assign blank = blank_lz[idx];
`else
    assign blank = 1'b0;
`endif

    // Registered pin drivers; dropping enable blanks the display on the same edge
    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            seg_q        <= SEG_OFF;
            dig_n_q      <= '1;
            frame_done_q <= 1'b0;
        end else begin
            if (bus.enable && (state == DRIVE)) begin
                dig_n_q <= N_DIGITS'(dig_onecold(3'(idx)));
                seg_q   <= blank ? SEG_OFF : lut_seg;
            end else begin
                dig_n_q <= '1;
                seg_q   <= SEG_OFF;
            end
            frame_done_q <= boundary;
        end
    end

    assign bus.seg        = seg_q;
    assign bus.dig_n      = dig_n_q;
    assign bus.frame_done = frame_done_q;

endmodule

// File: tb/tb_display_mux_hex_scan.sv
// Scoreboard bench for the hex scan controller: frame-position reference model vs registered pins.
// Expected pin values are queued per driven cycle and popped by an independent monitor.
// Build with LEADING_ZERO_BLANK_EN defined to exercise leading-zero blanking.
module tb_display_mux_hex_scan;

    localparam int N    = 4;
    localparam int D    = 4;
    localparam int G    = 1;
    localparam int SLOT = D + G;
    localparam int F    = N * SLOT;

    localparam logic [6:0] HEX_TAB [16] = '{
        7'h7E, 7'h30, 7'h6D, 7'h79, 7'h33, 7'h5B, 7'h5F, 7'h70,
        7'h7F, 7'h7B, 7'h77, 7'h1F, 7'h4E, 7'h3D, 7'h4F, 7'h47
    };

    typedef struct packed {
        logic [6:0] seg;
        logic [3:0] dig_n;
        logic       fd;
    } obs_t;

    logic clk;
    logic rst_n;

    display_mux_hex_scan_if #(.N_DIGITS(N)) bus ();

    display_mux_hex_scan #(
        .N_DIGITS  (N),
        .DWELL_CYC (D),
        .GUARD_CYC (G)
    ) dut (
        .clk   (clk),
        .rst_n (rst_n),
        .bus   (bus)
    );

    initial clk = 1'b0;
    always #5 clk = ~clk;

    int n_vec  = 0;
    int n_miss = 0;

    obs_t exp_q[$];

    // Reference model: frame position counter plus the three buffer values
    bit          m_running;
    int          m_pos;
    logic [15:0] m_active;
    logic [15:0] m_shadow;
    bit          m_pending;

    function automatic logic [6:0] digit_seg(input logic [15:0] a, input int k);
        logic [15:0] sh;
        sh = a >> (4 * k);
`ifdef LEADING_ZERO_BLANK_EN
        if (k > 0 && sh == 16'h0000) return 7'h00;
`endif
        return HEX_TAB[sh[3:0]];
    endfunction

    task automatic model_reset();
        m_running = 1'b0;
        m_pos     = 0;
        m_active  = '0;
        m_shadow  = '0;
        m_pending = 1'b0;
    endtask

    // Drive one cycle of inputs, queue the pin values expected after the coming edge
    task automatic step(input bit en, input bit ld, input logic [15:0] din);
        obs_t e;
        bit   bnd;
        int   dg;
        int   w;
        @(negedge clk);
        bus.enable  = en;
        bus.load    = ld;
        bus.data_in = din;

        e.seg   = 7'h00;
        e.dig_n = 4'hF;
        bnd     = en && m_running && (m_pos == F - 1);
        if (en && m_running) begin
            dg = m_pos / SLOT;
            w  = m_pos % SLOT;
            if (w < D) begin
                e.dig_n = 4'hF & ~(4'b0001 << dg);
                e.seg   = digit_seg(m_active, dg);
            end
        end
        e.fd = bnd;
        exp_q.push_back(e);

        if (!en) begin
            m_running = 1'b0;
            m_pos     = 0;
        end else if (!m_running) begin
            m_running = 1'b1;
            m_pos     = 0;
        end else begin
            m_pos = (m_pos + 1) % F;
        end

        if (bnd) begin
            if (ld) begin
                m_active = din;
                m_shadow = din;
            end else if (m_pending) begin
                m_active = m_shadow;
            end
            m_pending = 1'b0;
        end else if (ld) begin
            m_shadow  = din;
            m_pending = 1'b1;
        end
    endtask

    // Idle-run with enable high until the model reaches frame position p
    task automatic run_to(input int p);
        int guard;
        guard = 0;
        while ((!m_running || m_pos != p) && guard < 3 * F) begin
            step(1'b1, 1'b0, 16'h0000);
            guard++;
        end
    endtask

    task automatic check_off(input string tag);
        obs_t got;
        got = {bus.seg, bus.dig_n, bus.frame_done};
        n_vec++;
        if (got !== {7'h00, 4'hF, 1'b0}) begin
            n_miss++;
            $display("FAIL %s: got seg=%h dig_n=%b fd=%b, expected seg=00 dig_n=1111 fd=0",
                     tag, got.seg, got.dig_n, got.fd);
        end
    endtask

    // Monitor: after every edge, compare pins against the oldest queued expectation
    obs_t mon_exp;
    obs_t mon_got;
    initial begin
        forever begin
            @(posedge clk);
            #1;
            if (exp_q.size() > 0) begin
                mon_exp = exp_q.pop_front();
                mon_got = {bus.seg, bus.dig_n, bus.frame_done};
                n_vec++;
                if (mon_got !== mon_exp) begin
                    n_miss++;
                    $display("FAIL pins@%0t: got seg=%h dig_n=%b fd=%b, expected seg=%h dig_n=%b fd=%b",
                             $time, mon_got.seg, mon_got.dig_n, mon_got.fd,
                             mon_exp.seg, mon_exp.dig_n, mon_exp.fd);
                end
            end
        end
    end

    initial begin
        bit          en;
        bit          ld;
        logic [15:0] d;

        rst_n       = 1'b0;
        bus.enable  = 1'b0;
        bus.load    = 1'b0;
        bus.data_in = '0;
        model_reset();
        repeat (3) @(negedge clk);
        check_off("reset_state");
        rst_n = 1'b1;

        // First value, shown from the frame after the first boundary
        step(1'b1, 1'b1, 16'h1A08);
        repeat (45) step(1'b1, 1'b0, 16'h0000);

        // Two loads mid-frame: only the last one is ever displayed
        run_to(6);
        step(1'b1, 1'b1, 16'hFFFF);
        repeat (3) step(1'b1, 1'b0, 16'h0000);
        step(1'b1, 1'b1, 16'h0003);
        repeat (45) step(1'b1, 1'b0, 16'h0000);

        // Load on the boundary edge bypasses into the very next frame
        run_to(F - 1);
        step(1'b1, 1'b1, 16'hBEEF);
        repeat (25) step(1'b1, 1'b0, 16'h0000);

        // Enable dropped during digit 2 dwell; a load while disabled stays pending
        run_to(11);
        repeat (4) step(1'b0, 1'b0, 16'h0000);
        step(1'b0, 1'b1, 16'h4321);
        repeat (45) step(1'b1, 1'b0, 16'h0000);

        // Random traffic: sparse loads, rare single-cycle enable drops, small values for blanking
        for (int i = 0; i < 900; i++) begin
            en = ($urandom_range(0, 99) != 0);
            ld = ($urandom_range(0, 14) == 0);
            d  = ($urandom_range(0, 1) == 1) ? 16'($urandom) : 16'($urandom_range(0, 255));
            step(en, ld, d);
        end

        // Leading-zero pattern
        run_to(3);
        step(1'b1, 1'b1, 16'h0050);
        repeat (45) step(1'b1, 1'b0, 16'h0000);

        // Asynchronous reset while a digit is lit
        run_to(8);
        @(negedge clk);
        #2;
        rst_n = 1'b0;
        #1;
        check_off("async_reset");
        repeat (2) @(negedge clk);
        bus.enable = 1'b0;
        bus.load   = 1'b0;
        model_reset();
        rst_n = 1'b1;
        repeat (45) step(1'b1, 1'b0, 16'h0000);

        repeat (3) @(negedge clk);
        n_vec++;
        if (exp_q.size() != 0) begin
            n_miss++;
            $display("FAIL drain: %0d expectations left unchecked, required 0", exp_q.size());
        end

        $display("== %0d vectors applied, %0d miscompares ==", n_vec, n_miss);
        $finish;
    end

endmodule

// File: doc/display_mux_hex_scan.md
Name: display_mux_hex_scan

Overview:
- Time-multiplexed scan controller for an N-digit common-cathode 7-segment display; one hex-to-segment decoder is shared across all digits.
- Accepts a packed N-nibble word from the datapath and double-buffers it, so a new value is applied only at a frame boundary (no tearing).
- Sequences digit selects with a prescaled dwell time and an all-off guard interval between digits (anti-ghosting).
- Sits between the datapath and the FPGA display pins.

Parameters:
- N_DIGITS, 4, number of digits scanned (2..8).
- DWELL_CYC, 50000, clock cycles each digit is driven (>=2).
- GUARD_CYC, 500, all-digits-off cycles after each dwell (>=1).

Ports:
- clk  in  1  system clock, rising edge.
- rst_n  in  1  asynchronous active-low reset.
- enable  in  1  scanning enabled; low forces display off.
- load  in  1  single-cycle strobe capturing data_in.
- data_in  in  4*N_DIGITS  digit k = data_in[4k+3:4k]; digit 0 is least significant.
- seg  out  7  segments {a,b,c,d,e,f,g}, active-high (common cathode).
- dig_n  out  N_DIGITS  digit select, active-low; bit k drives digit k.
- frame_done  out  1  one-cycle pulse after the last digit's guard interval.

Behaviour:
- Reset (async, rst_n=0):
  - seg=0, dig_n=all 1, frame_done=0.
  - State OFF, digit index 0, prescaler 0.
  - Shadow and active buffers = 0, pending flag = 0.
- Buffering:
  - load=1 at an edge writes data_in to shadow and sets pending. Multiple loads within a frame: last wins.
  - At the frame-boundary edge with pending=1, active <= shadow and pending is cleared.
  - load coinciding with the boundary edge: data_in bypasses straight into active; pending ends 0.
- FSM: OFF, DRIVE, GUARD.
  - OFF: enable=1 -> DRIVE with index 0 and prescaler cleared.
  - DRIVE: lasts DWELL_CYC cycles, then -> GUARD.
  - GUARD: lasts GUARD_CYC cycles.
    - If index < N_DIGITS-1: index++, -> DRIVE.
    - Else: index=0, frame_done=1 for one cycle, buffer transfer, -> DRIVE.
  - enable=0 in any state -> OFF at the next edge. Index and prescaler are cleared; the partial frame is abandoned with no frame_done and no transfer. Shadow and pending are kept.
- Outputs are registered, one cycle behind state.
  - DRIVE: dig_n has only bit [index] low; seg = decode(active nibble [index]).
  - GUARD/OFF: dig_n=all 1, seg=0.
- Frame length = N_DIGITS*(DWELL_CYC+GUARD_CYC) cycles.
- Prescaler width = clog2(max(DWELL_CYC,GUARD_CYC)); no wrap beyond the terminal count.
- Decode table (abcdefg):
  - 0=7E, 1=30, 2=6D, 3=79, 4=33, 5=5B, 6=5F, 7=70
  - 8=7F, 9=7B, A=77, b=1F, C=4E, d=3D, E=4F, F=47
- Never more than one dig_n bit is low in any cycle.

Optional Feature:
- Macro LEADING_ZERO_BLANK_EN.
- Defined: a digit k>0 shows seg=0 (dig_n still asserted, timing unchanged) when active nibbles k..N_DIGITS-1 are all zero. Digit 0 is always shown, so value 0 displays a single "0".
- Undefined: every digit is always decoded.

Decomposition:
- Package display_pkg holds:
  - the state enum (OFF/DRIVE/GUARD);
  - the 16-entry SEG_HEX constant table;
  - SEG_OFF=7'h00;
  - a dig_n one-cold helper function.
- Sub-module hex_7seg_lut: purely combinational 4-bit -> 7-bit lookup built on SEG_HEX, instantiated once.

Test Plan (bench uses N_DIGITS=4, DWELL_CYC=4, GUARD_CYC=1, frame = 20 cycles):
- Reset, enable=1, load=1 with data_in=16'h1A08 -> after the first frame_done, the next frame shows digit0 seg=7F (dig_n=1110), digit1 7E, digit2 77, digit3 30. Each digit is held 4 cycles followed by 1 cycle of dig_n=1111.
- Mid-frame, load 16'hFFFF then 16'h0003 -> the current frame stays unchanged; the next frame shows 0003 (digit0 seg=79). The 16'hFFFF value never appears.
- load on the same edge as frame_done -> the new value appears from the immediately following digit0 dwell.
- enable dropped during digit2 dwell -> next cycle dig_n=1111 and seg=00, no frame_done. Re-enable -> scanning restarts at digit0.
- Assert rst_n=0 asynchronously mid-DRIVE -> outputs off immediately, without waiting for a clock edge. After release, active=0000 and all digits show 7E.
- With LEADING_ZERO_BLANK_EN, load 16'h0050 -> digit3 and digit2 show seg=00; digit1 shows 5B; digit0 shows 7E.
